// File: rtl/pe_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pe_out_fifo
// Purpose  : Output-side collector for the systolic PE array. Accepts 1 or 2
//            result elements per cycle and presents them as 4-element packed
//            words, one word per pop. A flush zero-pads the trailing partial
//            word so it can drain at the end of a tile.
// Options  : PE_OUT_FIFO_ERR_EN adds a sticky 2-bit err output
//            (err[0] dropped push, err[1] pop while no word was valid).
// Revision : 1.0 - initial release
// ============================================================================
module pe_out_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             psh,
  input  logic [1:0][WIDTH-1:0]  din,
  output logic [1:0]             psh_rdy,
  input  logic                   flush,
  input  logic                   pop,
  output logic [3:0][WIDTH-1:0]  dout,
  output logic                   dout_val,
  output logic                   empty
`ifdef PE_OUT_FIFO_ERR_EN
  ,
  output logic [1:0]             err
`endif
);

  localparam int CNTR = 4 * DEPTH;
  localparam int AW   = $clog2(CNTR);
  localparam int RW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;

  localparam logic [CW-1:0] c_cntr = CW'(CNTR);
  localparam logic [CW-1:0] c_word = CW'(4);

  // Word-granular addressing relies on DEPTH being a power of two >= 2
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("pe_out_fifo: DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  logic [AW-1:0]    r_wptr;
  logic [RW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_mem [CNTR];

  logic [CW-1:0] w_free;
  logic [1:0]    w_req_n;
  logic          w_push_ok;
  logic [1:0]    w_push_n;
  logic [1:0]    w_pad;
  logic          w_pad_en;
  logic          w_dout_val;
  logic          w_pop_ok;
  logic [AW-1:0] w_wptr_p1;
  logic [AW-1:0] w_wptr_next;
  logic [CW-1:0] w_cnt_next;

  assign w_free = c_cntr - r_cnt;

  // Requested element count; flush overrides any push and 2'b11 requests nothing
  always_comb begin
    w_req_n = 2'd0;
    if (!flush) begin
      case (psh)
        2'b01:   w_req_n = 2'd1;
        2'b10:   w_req_n = 2'd2;
        default: w_req_n = 2'd0;
      endcase
    end
  end

  // All-or-nothing acceptance against the space free at the start of the cycle
  assign w_push_ok = (w_req_n != 2'd0) && (CW'(w_req_n) <= w_free);
  assign w_push_n  = w_push_ok ? w_req_n : 2'd0;

  // Pad brings the write pointer up to the next 4-element boundary
  assign w_pad    = flush ? (2'd0 - r_wptr[1:0]) : 2'd0;
  assign w_pad_en = (w_pad != 2'd0);

  assign w_dout_val = (r_cnt >= c_word);
  assign w_pop_ok   = pop && w_dout_val;

  assign w_wptr_p1   = r_wptr + AW'(1);
  assign w_wptr_next = r_wptr + AW'(w_push_n) + AW'(w_pad);
  assign w_cnt_next  = r_cnt + CW'(w_push_n) + CW'(w_pad)
                       - (w_pop_ok ? c_word : {CW{1'b0}});

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      r_wptr <= w_wptr_next;
      r_cnt  <= w_cnt_next;
      if (w_pop_ok) begin
        r_rptr <= r_rptr + RW'(1);
      end
    end
  end

  // Element storage: each slot decodes its own write from push or pad
  generate
    for (genvar i = 0; i < CNTR; i++) begin : g_slot
      localparam logic [AW-1:0] c_idx = AW'(i);

      logic             w_we;
      logic [WIDTH-1:0] w_wd;
      logic [WIDTH-1:0] r_data;

      // Pad zeroes the tail of the partial word; pushes write at wptr / wptr+1
      always_comb begin
        w_we = 1'b0;
        w_wd = '0;
        if (w_pad_en && (c_idx[AW-1:2] == r_wptr[AW-1:2])
            && (c_idx[1:0] >= r_wptr[1:0])) begin
          w_we = 1'b1;
          w_wd = '0;
        end else if (w_push_ok && (c_idx == r_wptr)) begin
          w_we = 1'b1;
          w_wd = din[0];
        end else if (w_push_ok && (w_req_n == 2'd2) && (c_idx == w_wptr_p1)) begin
          w_we = 1'b1;
          w_wd = din[1];
        end
      end

      // Slot register, cleared on reset
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data <= '0;
        end else if (w_we) begin
          r_data <= w_wd;
        end
      end

      assign w_mem[i] = r_data;
    end
  endgenerate

  // Head word read-out, forced to zero while no complete word is held
  generate
    for (genvar k = 0; k < 4; k++) begin : g_dout
      localparam logic [1:0] c_k = 2'(k);
      assign dout[k] = w_dout_val ? w_mem[{r_rptr, c_k}] : '0;
    end
  endgenerate

  // Push credit derived from registered occupancy only
  always_comb begin
    psh_rdy = 2'b00;
    if (w_free >= CW'(2)) begin
      psh_rdy = 2'b10;
    end else if (w_free == CW'(1)) begin
      psh_rdy = 2'b01;
    end
  end

  assign dout_val = w_dout_val;
  assign empty    = (r_cnt == '0);

`ifdef PE_OUT_FIFO_ERR_EN
  logic [1:0] r_err;
  logic       w_drop;

  assign w_drop = (psh != 2'b00) && !flush && !w_push_ok;

  // Sticky error flags, only reset clears them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 2'b00;
    end else begin
      if (w_drop) begin
        r_err[0] <= 1'b1;
      end
      if (pop && !w_dout_val) begin
        r_err[1] <= 1'b1;
      end
    end
  end

  assign err = r_err;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_out_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_out_fifo
// Purpose  : Self-checking bench for pe_out_fifo (WIDTH=4, DEPTH=2): directed
//            vector table, hand sequences for wrap and async reset, then a
//            randomized run against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_out_fifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 2;
  localparam int CNTR  = 4 * DEPTH;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [1:0]            psh;
  logic [1:0][WIDTH-1:0] din;
  logic [1:0]            psh_rdy;
  logic                  flush;
  logic                  pop;
  logic [3:0][WIDTH-1:0] dout;
  logic                  dout_val;
  logic                  empty;
`ifdef PE_OUT_FIFO_ERR_EN
  logic [1:0]            err;
`endif

  pe_out_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .psh      (psh),
    .din      (din),
    .psh_rdy  (psh_rdy),
    .flush    (flush),
    .pop      (pop),
    .dout     (dout),
    .dout_val (dout_val),
    .empty    (empty)
`ifdef PE_OUT_FIFO_ERR_EN
    ,
    .err      (err)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  psh;
    logic [3:0]  d0;
    logic [3:0]  d1;
    logic        flush;
    logic        pop;
    logic [1:0]  rdy;
    logic        val;
    logic        emp;
    logic [15:0] dout;
  } vec_t;

  vec_t tbl[29];

  // Reference model state: the stored elements in arrival order
  int         q[$];
  logic [1:0] m_err;

  task automatic drive(input logic [1:0] p, input logic [3:0] d0, input logic [3:0] d1,
                       input logic f, input logic po);
    psh    = p;
    din[0] = d0;
    din[1] = d1;
    flush  = f;
    pop    = po;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string name, input logic [1:0] er, input logic ev,
                           input logic ee, input logic [15:0] ed);
    n_tests++;
    if (psh_rdy !== er || dout_val !== ev || empty !== ee || dout !== ed) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b val=%b empty=%b dout=%h, expected rdy=%b val=%b empty=%b dout=%h",
               name, psh_rdy, dout_val, empty, dout, er, ev, ee, ed);
    end
  endtask

  // Apply one cycle of stimulus to the model using start-of-cycle occupancy
  task automatic model_step(input logic [1:0] p, input logic [3:0] d0, input logic [3:0] d1,
                            input logic f, input logic po);
    int  n;
    int  pad;
    bit  drop;
    bit  do_pop;
    n      = f ? 0 : ((p == 2'b01) ? 1 : ((p == 2'b10) ? 2 : 0));
    drop   = !f && (p != 2'b00) && ((p == 2'b11) || (n > CNTR - q.size()));
    do_pop = po && (q.size() >= 4);
    pad    = f ? ((4 - (q.size() % 4)) % 4) : 0;
    if (drop) m_err[0] = 1'b1;
    if (po && !do_pop) m_err[1] = 1'b1;
    if (do_pop) repeat (4) void'(q.pop_front());
    if (!drop && n >= 1) q.push_back(int'(d0));
    if (!drop && n == 2) q.push_back(int'(d1));
    repeat (pad) q.push_back(0);
  endtask

  task automatic check_model(input int cyc);
    logic [1:0]  er;
    logic        ev;
    logic [15:0] ed;
    int          fr;
    fr = CNTR - q.size();
    er = (fr >= 2) ? 2'b10 : ((fr == 1) ? 2'b01 : 2'b00);
    ev = (q.size() >= 4);
    ed = ev ? {q[3][3:0], q[2][3:0], q[1][3:0], q[0][3:0]} : 16'h0;
    check_out($sformatf("rand%0d", cyc), er, ev, (q.size() == 0), ed);
`ifdef PE_OUT_FIFO_ERR_EN
    n_tests++;
    if (err !== m_err) begin
      n_fail++;
      $display("FAIL rand%0d.err: got %b expected %b", cyc, err, m_err);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         psh    d0    d1   fl  po   rdy  val emp dout
    tbl[0]  = '{2'b10, 4'h1, 4'h2, 0, 0, 2'b10, 0, 0, 16'h0000};
    tbl[1]  = '{2'b10, 4'h3, 4'h4, 0, 0, 2'b10, 1, 0, 16'h4321};
    tbl[2]  = '{2'b00, 4'h0, 4'h0, 0, 1, 2'b10, 0, 1, 16'h0000};
    tbl[3]  = '{2'b01, 4'h5, 4'h0, 0, 0, 2'b10, 0, 0, 16'h0000};
    tbl[4]  = '{2'b01, 4'h6, 4'h0, 0, 0, 2'b10, 0, 0, 16'h0000};
    tbl[5]  = '{2'b01, 4'h7, 4'h0, 0, 0, 2'b10, 0, 0, 16'h0000};
    tbl[6]  = '{2'b10, 4'h8, 4'h9, 0, 0, 2'b10, 1, 0, 16'h8765};
    tbl[7]  = '{2'b00, 4'h0, 4'h0, 0, 1, 2'b10, 0, 0, 16'h0000};
    tbl[8]  = '{2'b10, 4'hA, 4'hB, 0, 0, 2'b10, 0, 0, 16'h0000};
    tbl[9]  = '{2'b10, 4'hC, 4'hD, 0, 0, 2'b10, 1, 0, 16'hCBA9};
    tbl[10] = '{2'b01, 4'hE, 4'h0, 0, 0, 2'b10, 1, 0, 16'hCBA9};
    tbl[11] = '{2'b01, 4'hF, 4'h0, 0, 0, 2'b01, 1, 0, 16'hCBA9};
    tbl[12] = '{2'b10, 4'h1, 4'h2, 0, 0, 2'b01, 1, 0, 16'hCBA9};
    tbl[13] = '{2'b01, 4'h3, 4'h0, 0, 0, 2'b00, 1, 0, 16'hCBA9};
    tbl[14] = '{2'b11, 4'h4, 4'h5, 0, 0, 2'b00, 1, 0, 16'hCBA9};
    tbl[15] = '{2'b01, 4'h6, 4'h0, 0, 1, 2'b10, 1, 0, 16'h3FED};
    tbl[16] = '{2'b00, 4'h0, 4'h0, 0, 1, 2'b10, 0, 1, 16'h0000};
    tbl[17] = '{2'b10, 4'hC, 4'hD, 0, 0, 2'b10, 0, 0, 16'h0000};
    tbl[18] = '{2'b01, 4'hE, 4'h0, 0, 0, 2'b10, 0, 0, 16'h0000};
    tbl[19] = '{2'b10, 4'h7, 4'h7, 1, 0, 2'b10, 1, 0, 16'h0EDC};
    tbl[20] = '{2'b00, 4'h0, 4'h0, 1, 0, 2'b10, 1, 0, 16'h0EDC};
    tbl[21] = '{2'b00, 4'h0, 4'h0, 1, 1, 2'b10, 0, 1, 16'h0000};
    tbl[22] = '{2'b00, 4'h0, 4'h0, 0, 1, 2'b10, 0, 1, 16'h0000};
    tbl[23] = '{2'b11, 4'h9, 4'h9, 0, 0, 2'b10, 0, 1, 16'h0000};
    tbl[24] = '{2'b10, 4'h1, 4'h2, 0, 0, 2'b10, 0, 0, 16'h0000};
    tbl[25] = '{2'b10, 4'h3, 4'h4, 0, 0, 2'b10, 1, 0, 16'h4321};
    tbl[26] = '{2'b01, 4'h5, 4'h0, 0, 0, 2'b10, 1, 0, 16'h4321};
    tbl[27] = '{2'b00, 4'h0, 4'h0, 1, 1, 2'b10, 1, 0, 16'h0005};
    tbl[28] = '{2'b00, 4'h0, 4'h0, 0, 1, 2'b10, 0, 1, 16'h0000};

    rst_n = 1'b0;
    drive(2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    #12;
    check_out("reset", 2'b10, 1'b0, 1'b1, 16'h0000);
    #10;
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].psh, tbl[i].d0, tbl[i].d1, tbl[i].flush, tbl[i].pop);
      tick();
      check_out($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].val, tbl[i].emp, tbl[i].dout);
    end

    // Write wrap: three elements land in slots 4..6, then A/B straddle slot 7 and 0
    drive(2'b10, 4'h1, 4'h2, 1'b0, 1'b0); tick();
    drive(2'b01, 4'h3, 4'h0, 1'b0, 1'b0); tick();
    check_out("wrap_pre", 2'b10, 1'b0, 1'b0, 16'h0000);
    drive(2'b10, 4'hA, 4'hB, 1'b0, 1'b0); tick();
    check_out("wrap_word1", 2'b10, 1'b1, 1'b0, 16'hA321);
    drive(2'b00, 4'h0, 4'h0, 1'b0, 1'b1); tick();
    check_out("wrap_pop1", 2'b10, 1'b0, 1'b0, 16'h0000);
    drive(2'b10, 4'hC, 4'hD, 1'b0, 1'b0); tick();
    drive(2'b01, 4'hE, 4'h0, 1'b0, 1'b0); tick();
    check_out("wrap_word0", 2'b10, 1'b1, 1'b0, 16'hEDCB);
    drive(2'b00, 4'h0, 4'h0, 1'b0, 1'b1); tick();
    check_out("wrap_pop2", 2'b10, 1'b0, 1'b1, 16'h0000);

    // Asynchronous reset in the middle of a fill
    drive(2'b10, 4'h5, 4'h6, 1'b0, 1'b0); tick();
    drive(2'b10, 4'h7, 4'h8, 1'b0, 1'b0); tick();
    check_out("prerst_full", 2'b10, 1'b1, 1'b0, 16'h8765);
    drive(2'b01, 4'h9, 4'h0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 2'b10, 1'b0, 1'b1, 16'h0000);
    drive(2'b00, 4'h0, 4'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_out("post_rst", 2'b10, 1'b0, 1'b1, 16'h0000);

    // Randomized run against the queue model, alternating fill- and drain-heavy phases
    q.delete();
    m_err = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      logic [1:0] p;
      logic [3:0] d0;
      logic [3:0] d1;
      logic       f;
      logic       po;
      int         r;
      r  = int'($urandom_range(0, 9));
      p  = (r < 3) ? 2'b00 : ((r < 6) ? 2'b01 : ((r < 9) ? 2'b10 : 2'b11));
      d0 = 4'($urandom_range(0, 15));
      d1 = 4'($urandom_range(0, 15));
      f  = ($urandom_range(0, 9) == 0);
      po = ((c / 200) % 2 == 0) ? ($urandom_range(0, 99) < 15) : ($urandom_range(0, 99) < 50);
      drive(p, d0, d1, f, po);
      tick();
      model_step(p, d0, d1, f, po);
      check_model(c);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
